// File: rtl/behav_counter_driver.sv
// Command-driven stimulus/check engine for behav_counter with a cycle-accurate counter model.
// Latency: SAMPLE 1 cycle, CLEAR/LOAD 3 cycles, RUN len N -> N+2 cycles from accept to rsp_valid.
// Backpressure: cmd_ready only in IDLE; rsp_valid/rsp_q/rsp_err held stable until rsp_ready.
module behav_counter_driver #(
  parameter int WIDTH     = 8,
  parameter int LEN_WIDTH = 8,
  parameter int ERR_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [WIDTH-1:0]     cmd_data,
  input  logic                 cmd_dir,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  output logic [WIDTH-1:0]     d,
  output logic                 clear,
  output logic                 load,
  output logic                 up_down,
  input  logic [WIDTH-1:0]     qd,
  input  logic                 qd_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_q,
  output logic                 rsp_err,
  output logic [ERR_WIDTH-1:0] err_count
);

  localparam logic [2:0] RST_CLR  = 3'd0;
  localparam logic [2:0] IDLE     = 3'd1;
  localparam logic [2:0] S_CLR    = 3'd2;
  localparam logic [2:0] S_LD     = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;
  localparam logic [2:0] S_SETTLE = 3'd5;
  localparam logic [2:0] S_RSP    = 3'd6;

  localparam logic [1:0] OP_CLEAR  = 2'b00;
  localparam logic [1:0] OP_LOAD   = 2'b01;
  localparam logic [1:0] OP_RUN    = 2'b10;
  localparam logic [1:0] OP_SAMPLE = 2'b11;

  logic [2:0]           state_q,      state_d;
  logic [WIDTH-1:0]     d_q,          d_d;
  logic                 clear_q,      clear_d;
  logic                 load_q,       load_d;
  logic                 up_down_q,    up_down_d;
  logic                 rsp_valid_q,  rsp_valid_d;
  logic [WIDTH-1:0]     rsp_q_q,      rsp_q_d;
  logic                 rsp_err_q,    rsp_err_d;
  logic [ERR_WIDTH-1:0] err_cnt_q,    err_cnt_d;
  logic [WIDTH-1:0]     model_q,      model_d;
  logic                 chk_en_q,     chk_en_d;
  logic                 err_sticky_q, err_sticky_d;
  logic [LEN_WIDTH-1:0] run_cnt_q,    run_cnt_d;

  logic accept;
  logic miss;

  assign cmd_ready = (state_q == IDLE);
  assign d         = d_q;
  assign clear     = clear_q;
  assign load      = load_q;
  assign up_down   = up_down_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_q     = rsp_q_q;
  assign rsp_err   = rsp_err_q;
  assign err_count = err_cnt_q;

  // Model, checker and command FSM next-state; drives are registered so the model sees what the counter sees.
  always_comb begin
    accept = (state_q == IDLE) && cmd_valid;
    miss   = chk_en_q && ((qd != model_q) || (qd_b != ~model_q[0]));

    // The counter never stops: it is cleared, loaded, or steps in the current direction every edge.
    if (clear_q)        model_d = '0;
    else if (load_q)    model_d = d_q;
    else if (up_down_q) model_d = model_q + WIDTH'(1);
    else                model_d = model_q - WIDTH'(1);

    // A new command starts with a clean error flag; a miss in its accept cycle still counts globally.
    err_sticky_d = accept ? 1'b0 : (err_sticky_q | miss);
    err_cnt_d    = (miss && (err_cnt_q != '1)) ? err_cnt_q + ERR_WIDTH'(1) : err_cnt_q;

    state_d     = state_q;
    d_d         = d_q;
    clear_d     = 1'b0;
    load_d      = 1'b0;
    up_down_d   = up_down_q;
    rsp_valid_d = rsp_valid_q;
    rsp_q_d     = rsp_q_q;
    rsp_err_d   = rsp_err_q;
    chk_en_d    = chk_en_q;
    run_cnt_d   = run_cnt_q;

    case (state_q)
      RST_CLR: begin
        // The reset clear lands on this edge, so counter and model are both zero from here on.
        state_d  = IDLE;
        chk_en_d = 1'b1;
      end
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_CLEAR: begin
              clear_d = 1'b1;
              state_d = S_CLR;
            end
            OP_LOAD: begin
              load_d  = 1'b1;
              d_d     = cmd_data;
              state_d = S_LD;
            end
            OP_RUN: begin
              up_down_d = cmd_dir;
              run_cnt_d = (cmd_len == '0) ? LEN_WIDTH'(1) : cmd_len;
              state_d   = S_RUN;
            end
            default: begin
              // SAMPLE: respond straight away with the value visible this cycle.
              rsp_valid_d = 1'b1;
              rsp_q_d     = qd;
              rsp_err_d   = err_sticky_d;
              state_d     = S_RSP;
            end
          endcase
        end
      end
      S_CLR, S_LD: begin
        state_d = S_SETTLE;
      end
      S_RUN: begin
        if (run_cnt_q == LEN_WIDTH'(1)) state_d = S_SETTLE;
        else                            run_cnt_d = run_cnt_q - LEN_WIDTH'(1);
      end
      S_SETTLE: begin
        // qd now reflects the last drive; capture it as the response value.
        rsp_valid_d = 1'b1;
        rsp_q_d     = qd;
        rsp_err_d   = err_sticky_d;
        state_d     = S_RSP;
      end
      S_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = RST_CLR;
      end
    endcase
  end

  // State registers with synchronous reset; reset issues a one-cycle clear to the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RST_CLR;
      d_q          <= '0;
      clear_q      <= 1'b1;
      load_q       <= 1'b0;
      up_down_q    <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_q_q      <= '0;
      rsp_err_q    <= 1'b0;
      err_cnt_q    <= '0;
      model_q      <= '0;
      chk_en_q     <= 1'b0;
      err_sticky_q <= 1'b0;
      run_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      d_q          <= d_d;
      clear_q      <= clear_d;
      load_q       <= load_d;
      up_down_q    <= up_down_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_q_q      <= rsp_q_d;
      rsp_err_q    <= rsp_err_d;
      err_cnt_q    <= err_cnt_d;
      model_q      <= model_d;
      chk_en_q     <= chk_en_d;
      err_sticky_q <= err_sticky_d;
      run_cnt_q    <= run_cnt_d;
    end
  end

endmodule

// File: tb/tb_behav_counter_driver.sv
// Bench for behav_counter_driver: includes a behavioural counter on the drive side.
// Responses are checked by a scoreboard monitor; expected values are queued at command accept.
// Backpressure is exercised by holding rsp_ready low on one command.
module tb_behav_counter_driver;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic        cmd_dir;
  logic [7:0]  cmd_len;
  logic [7:0]  d;
  logic        clear;
  logic        load;
  logic        up_down;
  logic [7:0]  qd;
  logic        qd_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_q;
  logic        rsp_err;
  logic [15:0] err_count;

  logic [7:0]  cnt = 8'h00;
  logic        inj = 1'b0;
  logic        last_dir = 1'b1;
  logic [8:0]  exp_q[$];
  int          total = 0;
  int          bad = 0;

  behav_counter_driver #(.WIDTH(8), .LEN_WIDTH(8), .ERR_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_dir(cmd_dir), .cmd_len(cmd_len),
    .d(d), .clear(clear), .load(load), .up_down(up_down),
    .qd(qd), .qd_b(qd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_q(rsp_q), .rsp_err(rsp_err),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The counter under control: clear beats load, otherwise it steps every edge.
  always @(posedge clk) begin
    if (clear)        cnt <= 8'h00;
    else if (load)    cnt <= d;
    else if (up_down) cnt <= cnt + 8'd1;
    else              cnt <= cnt - 8'd1;
  end

  assign qd   = cnt;
  assign qd_b = inj ? 1'b0 : ~cnt[0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: one pop per response handshake.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (!rst && clear && load) begin
        total++;
        bad++;
        $display("FAIL clear_load_both: clear and load high together");
      end
      if (!rst && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp: got rsp_q=0x%0h with nothing expected", rsp_q);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_q", 32'(rsp_q), 32'(e[7:0]));
          chk("rsp_err", 32'(rsp_err), 32'(e[8]));
        end
      end
    end
  end

  // Issue one command; the expected response is derived from the counter value in the accept
  // cycle: the accept edge still steps with the previous direction, then RUN adds len steps.
  task automatic send(input logic [1:0] op, input logic [7:0] data, input logic dir,
                      input logic [7:0] len, input bit push, input bit exp_err);
    logic [7:0] c;
    logic [7:0] e;
    logic [7:0] n;
    bit         done;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_dir   = dir;
    cmd_len   = len;
    done      = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (cmd_ready) begin
        c = cnt;
        n = (len == 8'd0) ? 8'd1 : len;
        case (op)
          2'b00:   e = 8'h00;
          2'b01:   e = data;
          2'b10:   e = c + (last_dir ? 8'h01 : 8'hFF) + n * (dir ? 8'h01 : 8'hFF);
          default: e = c;
        endcase
        if (op == 2'b10) last_dir = dir;
        if (push) exp_q.push_back({exp_err, e});
        done = 1'b1;
        @(posedge clk);
        #1;
      end else begin
        @(negedge clk);
      end
    end
    cmd_valid = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL cmd_accept_timeout: op=%0d never accepted", op);
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(negedge clk);
    chk("rsp_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 8'h00;
    cmd_dir   = 1'b0;
    cmd_len   = 8'h00;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_d", 32'(d), 32'h00);
    chk("rst_clear", 32'(clear), 32'd1);
    chk("rst_load", 32'(load), 32'd0);
    chk("rst_up_down", 32'(up_down), 32'd1);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_q", 32'(rsp_q), 32'h00);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    rst = 1'b0;

    // Free-running sample straight after reset: counter has just been cleared.
    send(2'b11, 8'h00, 1'b0, 8'd0, 1'b1, 1'b0);
    wait_done();
    chk("err_count_clean", 32'(err_count), 32'd0);

    // Up-count wrap FE -> 01 and beyond.
    send(2'b01, 8'hFE, 1'b0, 8'd0, 1'b1, 1'b0);
    send(2'b10, 8'h00, 1'b1, 8'd3, 1'b1, 1'b0);
    // Down-count wrap through 00 to FF.
    send(2'b01, 8'h01, 1'b0, 8'd0, 1'b1, 1'b0);
    send(2'b10, 8'h00, 1'b0, 8'd4, 1'b1, 1'b0);
    // RUN with len 0 behaves as len 1.
    send(2'b10, 8'h00, 1'b1, 8'd0, 1'b1, 1'b0);
    wait_done();
    chk("err_count_wraps", 32'(err_count), 32'd0);

    // CLEAR with the response stalled for 5 cycles.
    rsp_ready = 1'b0;
    send(2'b00, 8'h00, 1'b0, 8'd0, 1'b1, 1'b0);
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall_rsp_q", 32'(rsp_q), 32'h00);
      chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_done();

    // qd_b stuck-at-0 in two cycles where it should be 1, inside a RUN.
    send(2'b10, 8'h00, 1'b1, 8'd12, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      for (int i = 0; i < 4 && cnt[0]; i++) @(negedge clk);
      inj = 1'b1;
      @(negedge clk);
      inj = 1'b0;
    end
    wait_done();
    chk("err_count_inject", 32'(err_count), 32'd2);
    send(2'b11, 8'h00, 1'b0, 8'd0, 1'b1, 1'b0);
    wait_done();
    chk("err_count_after_clean", 32'(err_count), 32'd2);

    // Reset in the middle of a long RUN: no response, counter cleared, back in IDLE.
    send(2'b10, 8'h00, 1'b0, 8'd200, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_dir = 1'b1;
    chk("abort_clear", 32'(clear), 32'd1);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_err_count", 32'(err_count), 32'd0);
    chk("abort_cmd_ready_0", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("abort_cmd_ready_1", 32'(cmd_ready), 32'd1);
    chk("abort_clear_done", 32'(clear), 32'd0);
    chk("abort_qd", 32'(qd), 32'h00);

    // Normal operation resumes.
    send(2'b01, 8'h5A, 1'b0, 8'd0, 1'b1, 1'b0);
    send(2'b11, 8'h00, 1'b0, 8'd0, 1'b1, 1'b0);
    wait_done();
    chk("err_count_final", 32'(err_count), 32'd0);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
